// File: rtl/demux_reg_pkg.sv
// Shared types and defaults for the registered 1-to-N demultiplexer.
// Lane-state encoding, default datapath sizes and a power-of-two helper.
package demux_reg_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_OUT    = 4;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    function automatic bit is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/demux_reg_if.sv
// Source/consumer bus of demux_reg: write side (D, S, in_valid/in_ready)
// plus the per-lane output side (Y, out_valid/out_ack, busy).
interface demux_reg_if
    import demux_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_OUT    = DEFAULT_NUM_OUT
);
    localparam int SEL_WIDTH = $clog2(NUM_OUT);

    logic [DATA_WIDTH-1:0]         D;
    logic [SEL_WIDTH-1:0]          S;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_OUT*DATA_WIDTH-1:0] Y;
    logic [NUM_OUT-1:0]            out_valid;
    logic [NUM_OUT-1:0]            out_ack;
    logic                          busy;

    modport master (
        output D, S, in_valid, out_ack,
        input  in_ready, Y, out_valid, busy
    );

    modport slave (
        input  D, S, in_valid, out_ack,
        output in_ready, Y, out_valid, busy
    );

endinterface

// File: rtl/demux_lane.sv
// One output lane of demux_reg: a 1-deep holding register with valid/ack.
//
//   state      | meaning
//   LANE_EMPTY | no unconsumed word; q keeps the last value taken
//   LANE_FULL  | q holds a word the consumer has not yet acked
module demux_lane
    import demux_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  valid
);

    lane_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Ack and write in the same cycle keeps the lane FULL with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr) begin
            data_d = wdata;
        end
        case (state_q)
            LANE_EMPTY: if (wr)         state_d = LANE_FULL;
            LANE_FULL:  if (ack && !wr) state_d = LANE_EMPTY;
            default:                    state_d = LANE_EMPTY;
        endcase
    end

    assign q     = data_q;
    assign valid = (state_q == LANE_FULL);

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-NUM_OUT demultiplexer: steers D into lane S when that lane
// is empty or being acked this cycle; the source stalls otherwise.
module demux_reg
    import demux_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_OUT    = DEFAULT_NUM_OUT
) (
    input  logic        clk,
    input  logic        reset,
    demux_reg_if.slave  bus
);

    localparam int SEL_WIDTH = $clog2(NUM_OUT);

    if (!is_pow2_ge2(NUM_OUT)) begin : g_bad_num_out
        $error("demux_reg: NUM_OUT must be a power of two and >= 2");
    end

    logic [NUM_OUT-1:0]            wr;
    logic [NUM_OUT-1:0]            valid;
    logic [NUM_OUT*DATA_WIDTH-1:0] y;
    logic                          ready;
    logic [SEL_WIDTH-1:0]          sel;

    assign sel   = bus.S;
    assign ready = ~valid[sel] | bus.out_ack[sel];

    always_comb begin
        wr = '0;
        if (bus.in_valid && ready) begin
            wr[sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        demux_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[k]),
            .wdata (bus.D),
            .ack   (bus.out_ack[k]),
            .q     (y[k*DATA_WIDTH +: DATA_WIDTH]),
            .valid (valid[k])
        );
    end

    // busy is an OR of the valid flops, so it moves on the same edge as out_valid.
    assign bus.in_ready  = ready;
    assign bus.Y         = y;
    assign bus.out_valid = valid;
    assign bus.busy      = |valid;

endmodule

// File: tb/tb_demux_reg.sv
// Directed self-checking bench for demux_reg with 8-bit data and 4 lanes.
module tb_demux_reg;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    demux_reg_if #(.DATA_WIDTH(8), .NUM_OUT(4)) bus ();

    demux_reg #(
        .DATA_WIDTH (8),
        .NUM_OUT    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.D        = '0;
        bus.S        = '0;
        bus.in_valid = 1'b0;
        bus.out_ack  = '0;

        step();
        check("rst_y",     32'(bus.Y),         32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy",  32'(bus.busy),      32'h0);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.S = 2'(s);
            #1;
            check($sformatf("rdy_after_rst_s%0d", s), 32'(bus.in_ready), 32'h1);
        end

        // single write to lane 2
        bus.S = 2'd2; bus.D = 8'hA5; bus.in_valid = 1'b1;
        #1;
        check("wr2_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        check("wr2_valid", 32'(bus.out_valid), 32'h4);
        check("wr2_y",     32'(bus.Y),         32'h00A5_0000);
        check("wr2_busy",  32'(bus.busy),      32'h1);

        // stall on full lane 1, then release with ack
        bus.S = 2'd1; bus.D = 8'h5A; bus.in_valid = 1'b1;
        step();
        bus.D = 8'h77;
        #1;
        check("stall_ready", 32'(bus.in_ready), 32'h0);
        step();
        check("stall_y",     32'(bus.Y),         32'h00A5_5A00);
        check("stall_valid", 32'(bus.out_valid), 32'h6);
        bus.out_ack = 4'b0010;
        #1;
        check("ack_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0; bus.out_ack = 4'b0000;
        check("ackwr_y",     32'(bus.Y),         32'h00A5_7700);
        check("ackwr_valid", 32'(bus.out_valid), 32'h6);
        bus.out_ack = 4'b0110;
        step();
        bus.out_ack = 4'b0000;
        check("clr12_valid", 32'(bus.out_valid), 32'h0);
        check("clr12_y",     32'(bus.Y),         32'h00A5_7700);

        // streaming on lane 0
        bus.S = 2'd0; bus.in_valid = 1'b1; bus.out_ack = 4'b0001;
        for (int d = 1; d <= 4; d++) begin
            bus.D = 8'(d);
            #1;
            check($sformatf("strm_ready_%0d", d), 32'(bus.in_ready), 32'h1);
            step();
            check($sformatf("strm_y_%0d", d),     32'(bus.Y[7:0]),       32'(d));
            check($sformatf("strm_v_%0d", d),     32'(bus.out_valid[0]), 32'h1);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ack = 4'b0000;
        check("strm_end_valid", 32'(bus.out_valid), 32'h0);
        check("strm_end_y",     32'(bus.Y),         32'h00A5_7704);

        // lane independence
        bus.S = 2'd3; bus.D = 8'h3C; bus.in_valid = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            bus.S = 2'(k); bus.D = 8'(8'h10 + k);
            #1;
            check($sformatf("ind_ready_%0d", k), 32'(bus.in_ready), 32'h1);
            step();
        end
        bus.in_valid = 1'b0;
        check("ind_y",     32'(bus.Y),         32'h3C12_1110);
        check("ind_valid", 32'(bus.out_valid), 32'hF);
        check("ind_busy",  32'(bus.busy),      32'h1);
        bus.out_ack = 4'b1111;
        step();
        bus.out_ack = 4'b0000;
        check("ackall_valid", 32'(bus.out_valid), 32'h0);
        check("ackall_busy",  32'(bus.busy),      32'h0);

        // spurious acks on empty lanes
        bus.out_ack = 4'b1111;
        step();
        step();
        bus.out_ack = 4'b0000;
        check("spur_valid", 32'(bus.out_valid), 32'h0);
        check("spur_y",     32'(bus.Y),         32'h3C12_1110);
        check("spur_busy",  32'(bus.busy),      32'h0);

        // asynchronous reset with lanes full
        bus.S = 2'd0; bus.D = 8'hC3; bus.in_valid = 1'b1;
        step();
        bus.S = 2'd3; bus.D = 8'h9E;
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.out_valid), 32'h9);
        #2 reset = 1'b1;
        #1;
        check("async_rst_y",     32'(bus.Y),         32'h0);
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_busy",  32'(bus.busy),      32'h0);
        step();
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.S = 2'(s);
            #1;
            check($sformatf("rdy_post_rst_s%0d", s), 32'(bus.in_ready), 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
